mem_port_arbiter: RTL

- Shares one single-ported synchronous memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline.
- Arbitrates requests and sequences each memory access over a fixed latency.
- Returns data and a one-cycle done pulse to the winning requester.
- Generates the stall signals that the hazards unit ORs into stallF/stallD and into the memory-stage hold.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/arb_priority_sel.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and default widths used by the core top and the memory port arbiter.
package cpu_pkg;

  // Default datapath widths of the CPU core
  localparam int CPU_WIDTH            = 32;
  localparam int CPU_INSTRUCTIONWIDTH = 16;

  // Arbiter FSM states: IDLE arbitrates, ACCESS sequences the memory latency
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // Requester that owns the access in flight
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner selection for the shared memory port.
// Data wins by default. After STARVELIMIT consecutive data grants taken while
// fetch was waiting, fetch wins the next contested arbitration.
module arb_priority_sel #(
  parameter  int STARVELIMIT = 4,
  localparam int SW          = $clog2(STARVELIMIT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetchReq,
  input  logic          dataReq,
  input  logic          grantEn,
  output logic          grantData,
  output logic [SW-1:0] streak
);

  logic          atLimit;
  logic [SW-1:0] streakNext;

  // Pick the winner and compute the streak value after this arbitration
  always_comb begin
    atLimit    = (streak == SW'(STARVELIMIT));
    grantData  = dataReq & ~(fetchReq & atLimit);
    streakNext = streak;
    if (grantEn) begin
      if (grantData && fetchReq) begin
        streakNext = atLimit ? streak : streak + SW'(1);
      end else begin
        streakNext = '0;
      end
    end
  end

  // Count consecutive data grants that made fetch wait
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else begin
      streak <= streakNext;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// the memory stage. Each access holds the port for a fixed latency, then
// returns registered data with a one-cycle done pulse to its owner.
//
// Requester handshake: a requester raises req with its address (and for data,
// we/wdata) and holds all of them stable until its done pulse. The done cycle
// is an arbitration cycle: a req still high in that cycle is a new request.
// A requester wanting a single access drops req during its done cycle.
// The FSM state is visible on busy (high exactly when in ACCESS).
module mem_port_arbiter import cpu_pkg::*; #(
  parameter int WIDTH            = CPU_WIDTH,
  parameter int INSTRUCTIONWIDTH = CPU_INSTRUCTIONWIDTH,
  parameter int LATENCY          = 2,
  parameter int STARVELIMIT      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetch_req,
  input  logic [WIDTH-1:0]            fetch_addr,
  output logic                        fetch_done,
  output logic [INSTRUCTIONWIDTH-1:0] fetch_rdata,
  input  logic                        data_req,
  input  logic                        data_we,
  input  logic [WIDTH-1:0]            data_addr,
  input  logic [WIDTH-1:0]            data_wdata,
  output logic                        data_done,
  output logic [WIDTH-1:0]            data_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [WIDTH-1:0]            mem_addr,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic [WIDTH-1:0]            mem_rdata,
  output logic                        fetch_stall,
  output logic                        data_stall,
  output logic                        busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVELIMIT + 1);

  arb_state_t                  state, stateNext;
  arb_owner_t                  owner, ownerNext;
  logic [CW-1:0]               cnt, cntNext;
  logic                        memEnQ, memEnNext;
  logic                        memWeQ, memWeNext;
  logic [WIDTH-1:0]            memAddrQ, memAddrNext;
  logic [WIDTH-1:0]            memWdataQ, memWdataNext;
  logic                        fetchDoneQ, fetchDoneNext;
  logic                        dataDoneQ, dataDoneNext;
  logic [INSTRUCTIONWIDTH-1:0] fetchRdataQ, fetchRdataNext;
  logic [WIDTH-1:0]            dataRdataQ, dataRdataNext;
  logic                        grantEn;
  logic                        grantData;
  logic [SW-1:0]               streak;

  arb_priority_sel #(
    .STARVELIMIT (STARVELIMIT)
  ) uPrioritySel (
    .clock     (clock),
    .reset     (reset),
    .fetchReq  (fetch_req),
    .dataReq   (data_req),
    .grantEn   (grantEn),
    .grantData (grantData),
    .streak    (streak)
  );

  // Next state and next register values for the arbitration/access sequence
  always_comb begin
    stateNext      = state;
    ownerNext      = owner;
    cntNext        = cnt;
    memEnNext      = memEnQ;
    memWeNext      = memWeQ;
    memAddrNext    = memAddrQ;
    memWdataNext   = memWdataQ;
    fetchDoneNext  = 1'b0;
    dataDoneNext   = 1'b0;
    fetchRdataNext = fetchRdataQ;
    dataRdataNext  = dataRdataQ;
    grantEn        = 1'b0;

    case (state)
      IDLE: begin
        memEnNext = 1'b0;
        memWeNext = 1'b0;
        if (fetch_req || data_req) begin
          grantEn   = 1'b1;
          memEnNext = 1'b1;
          stateNext = ACCESS;
          if (grantData) begin
            ownerNext    = DATA;
            memAddrNext  = data_addr;
            memWdataNext = data_wdata;
            memWeNext    = data_we;
            // Writes complete in one ACCESS cycle; reads wait out the latency
            cntNext      = data_we ? '0 : CW'(LATENCY - 1);
          end else begin
            ownerNext    = FETCH;
            memAddrNext  = fetch_addr;
            memWdataNext = '0;
            memWeNext    = 1'b0;
            cntNext      = CW'(LATENCY - 1);
          end
        end
      end

      ACCESS: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else begin
          if (owner == FETCH) begin
            fetchRdataNext = mem_rdata[INSTRUCTIONWIDTH-1:0];
            fetchDoneNext  = 1'b1;
          end else begin
            dataDoneNext = 1'b1;
            if (!memWeQ) begin
              dataRdataNext = mem_rdata;
            end
          end
          memEnNext = 1'b0;
          memWeNext = 1'b0;
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
        memEnNext = 1'b0;
        memWeNext = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= FETCH;
      cnt         <= '0;
      memEnQ      <= 1'b0;
      memWeQ      <= 1'b0;
      memAddrQ    <= '0;
      memWdataQ   <= '0;
      fetchDoneQ  <= 1'b0;
      dataDoneQ   <= 1'b0;
      fetchRdataQ <= '0;
      dataRdataQ  <= '0;
    end else begin
      state       <= stateNext;
      owner       <= ownerNext;
      cnt         <= cntNext;
      memEnQ      <= memEnNext;
      memWeQ      <= memWeNext;
      memAddrQ    <= memAddrNext;
      memWdataQ   <= memWdataNext;
      fetchDoneQ  <= fetchDoneNext;
      dataDoneQ   <= dataDoneNext;
      fetchRdataQ <= fetchRdataNext;
      dataRdataQ  <= dataRdataNext;
    end
  end

  assign fetch_done  = fetchDoneQ;
  assign fetch_rdata = fetchRdataQ;
  assign data_done   = dataDoneQ;
  assign data_rdata  = dataRdataQ;
  assign mem_en      = memEnQ;
  assign mem_we      = memWeQ;
  assign mem_addr    = memAddrQ;
  assign mem_wdata   = memWdataQ;
  assign fetch_stall = fetch_req & ~fetchDoneQ;
  assign data_stall  = data_req & ~dataDoneQ;
  assign busy        = (state != IDLE);

endmodule
